// File: rtl/led_pkg.sv
// Shared definitions for the LED blink arbiter and the LED blinker:
// FSM state encodings, default prescaler width and the tick terminal-count helper.
package led_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_OFF  = 2'd2,
        ST_GAP  = 2'd3
    } led_state_t;

    localparam int LED_CNT_WIDTH = 16;

    // Terminal count of a width-bit prescaler; the tick fires when the counter holds this value.
    function automatic logic [31:0] tick_value(input int width);
        return (32'h1 << width) - 32'h1;
    endfunction

endpackage

// File: rtl/led_blink_arbiter_if.sv
// Request/grant/LED bundle between the status sources (master) and the LED arbiter (slave).
interface led_blink_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int BLINK_W = 4
);
    localparam int OW = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]         req_i;
    logic [NUM_REQ*BLINK_W-1:0] blinks_i;
    logic [NUM_REQ-1:0]         gnt_o;
    logic [NUM_REQ-1:0]         done_o;
    logic                       busy_o;
    logic [OW-1:0]              owner_o;
    logic                       led_o;

    modport master (
        output req_i, blinks_i,
        input  gnt_o, done_o, busy_o, owner_o, led_o
    );

    modport slave (
        input  req_i, blinks_i,
        output gnt_o, done_o, busy_o, owner_o, led_o
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or above i_ptr, wrapping modulo NUM_REQ.
module rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         i_req,
    input  logic [$clog2(NUM_REQ)-1:0] i_ptr,
    output logic [NUM_REQ-1:0]         o_gnt,
    output logic [$clog2(NUM_REQ)-1:0] o_idx,
    output logic                       o_valid
);
    localparam int IW = $clog2(NUM_REQ);

    logic [IW-1:0] w_k;

    function automatic int wrap_idx(input int base, input int off);
        int s;
        s = base + off;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return s;
    endfunction

    always_comb begin
        o_gnt   = '0;
        o_idx   = '0;
        o_valid = 1'b0;
        w_k     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_k = IW'(wrap_idx(int'(i_ptr), i));
            if (!o_valid && i_req[w_k]) begin
                o_valid    = 1'b1;
                o_gnt[w_k] = 1'b1;
                o_idx      = w_k;
            end
        end
    end

endmodule

// File: rtl/led_blink_arbiter.sv
// Shares one LED between NUM_REQ requesters: round-robin grant, then B blinks of one
// prescaler period on/off each, followed by GAP_TICKS dark periods before the next grant.
module led_blink_arbiter
    import led_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int CNT_WIDTH = LED_CNT_WIDTH,
    parameter int BLINK_W   = 4,
    parameter int GAP_TICKS = 2
) (
    input  logic                clk_i,
    input  logic                arstn_i,
    led_blink_arbiter_if.slave  bus
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int GW = $clog2(GAP_TICKS + 1);
    localparam logic [CNT_WIDTH-1:0] TICK_CNT = CNT_WIDTH'(tick_value(CNT_WIDTH));
    localparam logic [GW-1:0]        GAP_LAST = GW'(GAP_TICKS - 1);
    localparam logic [IW-1:0]        LAST_REQ = IW'(NUM_REQ - 1);

    led_state_t           r_state, w_state_next;
    logic [CNT_WIDTH-1:0] r_cnt, w_cnt_next;
    logic [BLINK_W-1:0]   r_rem, w_rem_next;
    logic [GW-1:0]        r_gap, w_gap_next;
    logic [IW-1:0]        r_ptr, w_ptr_next;
    logic [IW-1:0]        r_owner, w_owner_next;
    logic [NUM_REQ-1:0]   r_gnt, w_gnt_next;
    logic [NUM_REQ-1:0]   r_done, w_done_next;
    logic                 r_led, w_led_next;

    logic                 w_tick;
    logic [NUM_REQ-1:0]   w_arb_gnt;
    logic [IW-1:0]        w_arb_idx;
    logic                 w_arb_valid;
    logic [BLINK_W-1:0]   w_blinks [NUM_REQ];

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_blinks
        assign w_blinks[gi] = bus.blinks_i[gi*BLINK_W +: BLINK_W];
    end

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .i_req   (bus.req_i),
        .i_ptr   (r_ptr),
        .o_gnt   (w_arb_gnt),
        .o_idx   (w_arb_idx),
        .o_valid (w_arb_valid)
    );

    assign w_tick = (r_cnt == TICK_CNT);

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt + CNT_WIDTH'(1);
        w_rem_next   = r_rem;
        w_gap_next   = r_gap;
        w_ptr_next   = r_ptr;
        w_owner_next = r_owner;
        w_gnt_next   = '0;
        w_done_next  = '0;
        w_led_next   = r_led;
        case (r_state)
            ST_IDLE: begin
                if (w_arb_valid) begin
                    // Restart the prescaler so every phase of the pattern is exactly one period.
                    w_cnt_next   = '0;
                    w_gnt_next   = w_arb_gnt;
                    w_owner_next = w_arb_idx;
                    w_rem_next   = w_blinks[w_arb_idx];
                    w_ptr_next   = (w_arb_idx == LAST_REQ) ? '0 : w_arb_idx + 1'b1;
                    w_gap_next   = '0;
                    if (w_blinks[w_arb_idx] == '0) begin
                        w_done_next  = w_arb_gnt;
                        w_state_next = ST_GAP;
                    end else begin
                        w_led_next   = 1'b1;
                        w_state_next = ST_ON;
                    end
                end
            end
            ST_ON: begin
                if (w_tick) begin
                    w_led_next   = 1'b0;
                    w_state_next = ST_OFF;
                end
            end
            ST_OFF: begin
                if (w_tick) begin
                    if (r_rem <= BLINK_W'(1)) begin
                        w_rem_next           = '0;
                        w_done_next[r_owner] = 1'b1;
                        w_gap_next           = '0;
                        w_state_next         = ST_GAP;
                    end else begin
                        w_rem_next   = r_rem - BLINK_W'(1);
                        w_led_next   = 1'b1;
                        w_state_next = ST_ON;
                    end
                end
            end
            ST_GAP: begin
                if (w_tick) begin
                    if (r_gap == GAP_LAST) w_state_next = ST_IDLE;
                    else                   w_gap_next   = r_gap + GW'(1);
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_rem   <= '0;
            r_gap   <= '0;
            r_ptr   <= '0;
            r_owner <= '0;
            r_gnt   <= '0;
            r_done  <= '0;
            r_led   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_rem   <= w_rem_next;
            r_gap   <= w_gap_next;
            r_ptr   <= w_ptr_next;
            r_owner <= w_owner_next;
            r_gnt   <= w_gnt_next;
            r_done  <= w_done_next;
            r_led   <= w_led_next;
        end
    end

    assign bus.gnt_o   = r_gnt;
    assign bus.done_o  = r_done;
    assign bus.busy_o  = (r_state != ST_IDLE);
    assign bus.owner_o = r_owner;
    assign bus.led_o   = r_led;

endmodule
